// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Two-channel push-button conditioner. Debounces the raw button
//            inputs and produces clean levels plus one-cycle rising-edge
//            pulses. A shared free-running N-bit counter provides the
//            sampling tick. Each channel runs its own 8-state debounce FSM.
// Ports    : clk     - system clock, all logic on the rising edge
//            reset   - asynchronous, active-high
//            a_raw   - raw button A (may bounce)
//            b_raw   - raw button B (may bounce)
//            a_db    - debounced level A
//            b_db    - debounced level B
//            a_tick  - one-cycle pulse on the a_db rising edge
//            b_tick  - one-cycle pulse on the b_db rising edge
// Params   : N       - sample-counter width; tick period is 2^N clk cycles
// Macros   : BTN_SYNC_EN - when defined, each raw input passes through a
//            2-flop synchronizer before its FSM (adds 2 cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
  parameter int N = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_tick,
  output logic b_tick
);

  typedef enum logic [2:0] {
    zero    = 3'd0,
    wait1_1 = 3'd1,
    wait1_2 = 3'd2,
    wait1_3 = 3'd3,
    one     = 3'd4,
    wait0_1 = 3'd5,
    wait0_2 = 3'd6,
    wait0_3 = 3'd7
  } state_t;

  // Shared sample-tick counter.
  logic [N-1:0] q;
  logic         m_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q + 1'b1;
    end
  end

  assign m_tick = (q == {N{1'b1}});

  // Channel inputs: bit 0 is A, bit 1 is B.
  logic [1:0] raw_in;
  logic [1:0] x;
  logic [1:0] db;
  logic [1:0] tick;

  assign raw_in = {b_raw, a_raw};

`ifdef BTN_SYNC_EN
  logic [1:0] sync1;
  logic [1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign x = sync2;
`else
  assign x = raw_in;
`endif

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_t state_reg;
    state_t state_next;
    logic   db_reg;
    logic   tick_reg;

    // db and tick are registered from the next-state decode so they change
    // on the same edge as the state and cannot glitch.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_reg <= zero;
        db_reg    <= 1'b0;
        tick_reg  <= 1'b0;
      end else begin
        state_reg <= state_next;
        db_reg    <= (state_next == one)     || (state_next == wait0_1) ||
                     (state_next == wait0_2) || (state_next == wait0_3);
        // Only the wait1_3 -> one transition is a genuine press; a return
        // to one from wait0_k was a bounce on release and must not pulse.
        tick_reg  <= (state_reg == wait1_3) && (state_next == one);
      end
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        zero:    if (x[ch]) state_next = wait1_1;
        wait1_1: if (!x[ch]) state_next = zero;
                 else if (m_tick) state_next = wait1_2;
        wait1_2: if (!x[ch]) state_next = zero;
                 else if (m_tick) state_next = wait1_3;
        wait1_3: if (!x[ch]) state_next = zero;
                 else if (m_tick) state_next = one;
        one:     if (!x[ch]) state_next = wait0_1;
        wait0_1: if (x[ch]) state_next = one;
                 else if (m_tick) state_next = wait0_2;
        wait0_2: if (x[ch]) state_next = one;
                 else if (m_tick) state_next = wait0_3;
        wait0_3: if (x[ch]) state_next = one;
                 else if (m_tick) state_next = zero;
        default: state_next = zero;
      endcase
    end

    assign db[ch]   = db_reg;
    assign tick[ch] = tick_reg;
  end : g_chan

  assign a_db   = db[0];
  assign b_db   = db[1];
  assign a_tick = tick[0];
  assign b_tick = tick[1];

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
# btn_conditioner

Two-channel push-button conditioner that debounces raw mechanical inputs and produces clean levels plus one-cycle rising-edge pulses. Sits directly upstream of the generic FSM stage and drives its `a`/`b` inputs, either the level outputs or the tick outputs, with glitch-free, clock-synchronous signals. A shared free-running counter provides the sampling tick, and each channel runs an independent 8-state debounce FSM.

## Interface
- `N`, default 19: sample-counter width; tick period is 2^N clk cycles (5.24 ms at 100 MHz).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `a_raw`  in  1  raw button A, asynchronous, may bounce.
- `b_raw`  in  1  raw button B, asynchronous, may bounce.
- `a_db`  out  1  debounced level A.
- `b_db`  out  1  debounced level B.
- `a_tick`  out  1  one-cycle pulse on the `a_db` rising edge.
- `b_tick`  out  1  one-cycle pulse on the `b_db` rising edge.

## Operation
- Counter `q` is N bits and increments every cycle, wrapping from 2^N−1 to 0. `m_tick = (q == 2^N−1)`. It is shared by both channels.
- Per-channel FSM states: `zero`, `wait1_1`, `wait1_2`, `wait1_3`, `one`, `wait0_1`, `wait0_2`, `wait0_3`. Input `x` is the channel's (optionally synchronized) raw input.
- `zero`: if `x`, go to `wait1_1`; otherwise stay.
- `wait1_k`: if `!x`, go to `zero` immediately. Otherwise, on `m_tick`, advance to `wait1_{k+1}`. From `wait1_3`, advance to `one`. Otherwise hold.
- `one`: if `!x`, go to `wait0_1`; otherwise stay.
- `wait0_k`: if `x`, go to `one` immediately. Otherwise, on `m_tick`, advance. From `wait0_3`, advance to `zero`. Otherwise hold.
- `db` = 1 in `one` and in `wait0_1..3`; 0 in all other states.
- `tick` = 1 for exactly the first cycle in which `state_reg == one` after leaving `wait1_3`. It is registered, so it rises with `db`. Returning to `one` from `wait0_k` does not pulse. A falling edge never pulses.
- Illegal or default state goes to `zero`.
- Channels are fully independent. Simultaneous activity on A and B is legal, and both channels can pulse in the same cycle.

## Timing
- Reset values: `q`=0, both FSMs in `zero`, `a_db`=`b_db`=0, `a_tick`=`b_tick`=0. Sync flops are 0 when the macro is enabled.
- Reset mid-operation aborts any wait sequence. If the input is still high after reset releases, a full debounce is required before `db` rises again.
- Rise latency: edge E0 is the first edge sampling `x`=1 in `zero`, which enters `wait1_1`. `db`/`tick` rise at E0 + 2·2^N + k, with k in 1..2^N depending on counter phase.
- Fall latency is symmetric, measured from the first edge sampling `x`=0 in `one`.
- A bounce shorter than the wait window returns the FSM to its stable state with no output change.
- `m_tick` sampled in `zero` or `one` is not counted.

## Configuration
- `BTN_SYNC_EN` defined: each raw input passes through a 2-flop synchronizer before its FSM. This adds exactly 2 cycles to every latency above.
- `BTN_SYNC_EN` undefined: raw inputs drive the FSMs directly, and the caller guarantees synchronous inputs.

## Test plan
All scenarios use N=3 with `BTN_SYNC_EN` undefined unless stated.
- Clean press: raise `a_raw` and hold. `a_db` and `a_tick` rise together 17–24 cycles after E0. `a_tick` is high for exactly 1 cycle. B outputs stay 0.
- Bounce rejection: press `a_raw` and drop it after 5 cycles in `wait1_x`, toggling every 3 cycles for 30 cycles, then hold low. `a_db` and `a_tick` never assert.
- Release: from `a_db`=1, drop `a_raw` and hold. `a_db` falls 17–24 cycles later with no `a_tick`. A brief 1-cycle re-press during `wait0_x` returns the FSM to `one` with `a_db` held at 1 and no tick.
- Simultaneous press: raise `a_raw` and `b_raw` on the same cycle. `a_db`/`b_db` and `a_tick`/`b_tick` assert on the identical cycle.
- Reset mid-wait: assert `reset` while channel A is in `wait1_2` with `a_raw` still high. All outputs are 0 immediately. After release, `a_db` rises 17–24 cycles after the first post-reset edge.
- Sync build: with `BTN_SYNC_EN` defined, repeat the clean-press case. The latency window becomes 19–26 cycles from the `a_raw` rise.
